// File: rtl/jk_sync_counter_pkg.sv
// Shared constants for the JK-flip-flop synchronous counter.
//   WIDTH_DEF : default counter bit width
//   MOD_DEF   : default count modulus
//   dir_e     : encoding of the up_dn direction input
package jk_counter_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int MOD_DEF   = 10;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/jk_sync_counter_if.sv
// Control/status bundle of the JK synchronous counter.
//   en, up_dn, load, d : driven by the controller (master)
//   q, j_vec, k_vec, tc: driven by the counter (slave)
interface jk_sync_counter_if
    import jk_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic             tc;

    modport master (
        output en, up_dn, load, d,
        input  q, j_vec, k_vec, tc
    );

    modport slave (
        input  en, up_dn, load, d,
        output q, j_vec, k_vec, tc
    );

endinterface

// File: rtl/jk_sync_counter_ff.sv
// Single JK flip-flop, asynchronous active-high reset to 0.
//   j, k  : excitation inputs (00 hold, 01 clear, 10 set, 11 toggle)
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   q     : stored bit
//   q_bar : complement of q
module jk_ff_r (
    input  logic j,
    input  logic k,
    input  logic clk,
    input  logic rst,
    output logic q,
    output logic q_bar
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo-MOD up/down counter built from WIDTH JK flip-flops.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (count -> 0)
//   bus : slave side of jk_sync_counter_if
//         en/up_dn/load/d in; q (registered count), j_vec/k_vec
//         (excitation applied this cycle), tc (combinational terminal count) out
module jk_sync_counter
    import jk_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int MOD   = MOD_DEF
) (
    input  logic               clk,
    input  logic               rst,
    jk_sync_counter_if.slave   bus
);

    // One extra bit so MOD = 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j_c;
    logic [WIDTH-1:0] k_c;
    logic [WIDTH-1:0] q_bar_unused;
    logic             tc_c;

    // Priority rst > load > en. While in reset nxt follows q, which forces
    // J=K=0; an out-of-range q steps to 0 on any count.
    always_comb begin
        nxt  = q_r;
        tc_c = 1'b0;
        if (!rst) begin
            if (bus.load) begin
                nxt = ({1'b0, bus.d} < MOD_W) ? bus.d : '0;
            end else if (bus.en) begin
                if ({1'b0, q_r} >= MOD_W) begin
                    nxt = '0;
                end else if (bus.up_dn == DIR_UP) begin
                    nxt  = (q_r == MAX_Q) ? '0 : q_r + 1'b1;
                    tc_c = (q_r == MAX_Q);
                end else begin
                    nxt  = (q_r == '0) ? MAX_Q : q_r - 1'b1;
                    tc_c = (q_r == '0);
                end
            end
        end
        j_c = ~q_r & nxt;
        k_c = q_r & ~nxt;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_ff_r u_ff (
            .j     (j_c[i]),
            .k     (k_c[i]),
            .clk   (clk),
            .rst   (rst),
            .q     (q_r[i]),
            .q_bar (q_bar_unused[i])
        );
    end

    assign bus.q     = q_r;
    assign bus.j_vec = j_c;
    assign bus.k_vec = k_c;
    assign bus.tc    = tc_c;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed self-checking bench for jk_sync_counter (WIDTH=4, MOD=10).
module tb_jk_sync_counter;
    import jk_counter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    jk_sync_counter_if #(.WIDTH(4)) bus ();

    jk_sync_counter #(.WIDTH(4), .MOD(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    logic [3:0] exp_up [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};

    initial begin
        // Reset with en=1, up_dn=0: tc would be 1 at q=0 without reset.
        rst = 1'b1; bus.en = 1'b1; bus.up_dn = DIR_DOWN; bus.load = 1'b0; bus.d = 4'd0;
        #1;
        chk4("rst_q", bus.q, 4'd0);
        chk4("rst_j", bus.j_vec, 4'd0);
        chk4("rst_k", bus.k_vec, 4'd0);
        chk1("rst_tc", bus.tc, 1'b0);
        tick();
        tick();
        chk4("rst_hold_q", bus.q, 4'd0);

        // Release and count up 12 edges.
        rst = 1'b0; bus.up_dn = DIR_UP;
        #1;
        chk1("up0_tc", bus.tc, 1'b0);
        chk4("up0_j", bus.j_vec, 4'b0001);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk4($sformatf("up_q%0d", i), bus.q, exp_up[i]);
            chk1($sformatf("up_tc%0d", i), bus.tc, exp_up[i] == 4'd9);
        end

        // Down from 2: 1, 0, 9, 8.
        bus.up_dn = DIR_DOWN;
        tick();
        chk4("dn_q1", bus.q, 4'd1);
        chk1("dn_tc1", bus.tc, 1'b0);
        chk4("dn_k1", bus.k_vec, 4'b0001);
        tick();
        chk4("dn_q0", bus.q, 4'd0);
        chk1("dn_tc0", bus.tc, 1'b1);
        chk4("dn_j0", bus.j_vec, 4'b1001);
        chk4("dn_k0", bus.k_vec, 4'b0000);
        tick();
        chk4("dn_q9", bus.q, 4'd9);
        chk1("dn_tc9", bus.tc, 1'b0);
        tick();
        chk4("dn_q8", bus.q, 4'd8);

        // Loads with en=1; d>=MOD goes to 0.
        bus.load = 1'b1; bus.d = 4'd12;
        #1;
        chk1("ld12_tc", bus.tc, 1'b0);
        chk4("ld12_k", bus.k_vec, 4'b1000);
        tick();
        chk4("ld12_q", bus.q, 4'd0);
        bus.d = 4'd6;
        #1;
        chk1("ld6_tc", bus.tc, 1'b0);
        chk4("ld6_j", bus.j_vec, 4'b0110);
        tick();
        chk4("ld6_q", bus.q, 4'd6);
        bus.d = 4'd9;
        tick();
        chk4("ld9_q", bus.q, 4'd9);
        bus.d = 4'd10;
        tick();
        chk4("ld10_q", bus.q, 4'd0);
        bus.en = 1'b0; bus.d = 4'd3;
        tick();
        chk4("ld_noen_q", bus.q, 4'd3);

        // Hold for 5 edges.
        bus.load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk4($sformatf("hold_q%0d", i), bus.q, 4'd3);
            chk4($sformatf("hold_j%0d", i), bus.j_vec, 4'd0);
            chk4($sformatf("hold_k%0d", i), bus.k_vec, 4'd0);
            chk1($sformatf("hold_tc%0d", i), bus.tc, 1'b0);
        end

        // Direction toggle from 5.
        bus.load = 1'b1; bus.d = 4'd5;
        tick();
        chk4("tg_q5", bus.q, 4'd5);
        bus.load = 1'b0; bus.en = 1'b1; bus.up_dn = DIR_UP;
        #1;
        chk4("tg_j", bus.j_vec, 4'b0010);
        chk4("tg_k", bus.k_vec, 4'b0001);
        tick();
        chk4("tg_q6", bus.q, 4'd6);
        bus.up_dn = DIR_DOWN;
        tick();
        chk4("tg_q5b", bus.q, 4'd5);

        // Asynchronous reset between edges at q=7.
        bus.load = 1'b1; bus.d = 4'd7;
        tick();
        chk4("ar_q7", bus.q, 4'd7);
        bus.load = 1'b0; bus.up_dn = DIR_UP;
        #2;
        rst = 1'b1;
        #1;
        chk4("ar_q0", bus.q, 4'd0);
        chk4("ar_j", bus.j_vec, 4'd0);
        chk4("ar_k", bus.k_vec, 4'd0);
        chk1("ar_tc", bus.tc, 1'b0);
        #2;
        chk4("ar_edge_q", bus.q, 4'd0);
        rst = 1'b0;
        tick();
        chk4("ar_resume_q", bus.q, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jk_sync_counter.md
JK_SYNC_COUNTER -- requirements
Module: jk_sync_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the counter bit width.
REQ-002 The block SHALL have parameter MOD, default 10, meaning the count modulus (2 <= MOD <= 2^WIDTH).
REQ-003 The block SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port en  input  1  count enable.
REQ-006 The block SHALL have port up_dn  input  1  direction: 1 = up, 0 = down.
REQ-007 The block SHALL have port load  input  1  synchronous parallel load strobe.
REQ-008 The block SHALL have port d  input  WIDTH  parallel load value.
REQ-009 The block SHALL have port q  output  WIDTH  current count, registered.
REQ-010 The block SHALL have port j_vec  output  WIDTH  per-bit J excitation applied this cycle.
REQ-011 The block SHALL have port k_vec  output  WIDTH  per-bit K excitation applied this cycle.
REQ-012 The block SHALL have port tc  output  1  terminal-count flag, combinational.

Function
REQ-013 Each state bit SHALL be a JK flip-flop; the next count SHALL be produced only by driving J/K, with no direct D-path.
REQ-014 Excitation SHALL be j_vec[i] = ~q[i] & nxt[i] and k_vec[i] = q[i] & ~nxt[i], where nxt is the intended next count; a held bit gives J=K=0.
REQ-015 Priority SHALL be rst > load > en; when load=1 and en=0, the block loads, and when load=0 and en=0, it holds (nxt = q).
REQ-016 On load with d < MOD, nxt SHALL be d; with d >= MOD, nxt SHALL be 0.
REQ-017 On count up, nxt SHALL be q+1, with wrap from MOD-1 to 0.
REQ-018 On count down, nxt SHALL be q-1, with wrap from 0 to MOD-1.
REQ-019 Latency SHALL be one clock: q reflects nxt after the rising edge at which load/en were sampled.
REQ-020 tc SHALL be 1 exactly when en=1, load=0, and (up_dn=1 and q=MOD-1) or (up_dn=0 and q=0).
REQ-021 Changing up_dn mid-count SHALL take effect at the next edge with no dead cycle.
REQ-022 If q is ever outside 0..MOD-1, any count step SHALL set nxt to 0 (self-correcting).
REQ-023 All arithmetic SHALL be WIDTH bits wide, with no carry-out port.

Reset
REQ-024 When rst is asserted, q SHALL become 0 immediately, independent of clk.
REQ-025 While rst is high, j_vec and k_vec SHALL be 0, and tc SHALL be 0.
REQ-026 When rst is deasserted mid-operation, counting SHALL resume from 0 at the first subsequent edge with en=1.

Structure
REQ-027 The defaults for WIDTH and MOD, and the up_dn encoding constants, SHALL reside in the shared package jk_counter_pkg.
REQ-028 The block SHALL contain one sub-module, jk_ff_r, a single JK flip-flop with async active-high reset and ports j, k, clk, rst, q, q_bar, instantiated WIDTH times; the q_bar outputs SHALL be left unused.
REQ-029 Next-state and excitation logic SHALL be a single combinational block in jk_sync_counter.

Verification (WIDTH=4, MOD=10)
REQ-030 Scenario: rst=1 pulsed asynchronously between edges with q=7 -> q=0 before the next edge; j_vec=k_vec=0 during reset.
REQ-031 Scenario: en=1, up_dn=1 for 12 edges from 0 -> q = 1..9, 0, 1, 2; tc=1 only while q=9.
REQ-032 Scenario: en=1, up_dn=0 from q=1 -> q = 0, 9, 8; tc=1 while q=0; at q=0, j_vec=4'b1001 and k_vec=4'b0000.
REQ-033 Scenario: load=1, d=6 with en=1 -> q=6 next edge; load=1, d=12 -> q=0; tc=0 during both.
REQ-034 Scenario: en=0, load=0 for 5 edges at q=3 -> q stays 3; j_vec=k_vec=0; tc=0.
REQ-035 Scenario: at q=5, toggle up_dn 1->0 with en=1 -> q sequence 6, then 5; at the 5->6 edge, j_vec=4'b0010 and k_vec=4'b0001.
